// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the sequence run controller:
//   - default datapath widths
//   - controller state encoding
//   - resolved-command encoding plus the priority resolver used when several
//     command pulses arrive in the same cycle
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_LOOP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Resolved command for one cycle. A larger encoding outranks a smaller
    // one: stop beats pause, pause beats go (go = start or resume).
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_GO    = 2'd1,
        CMD_PAUSE = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_e;

    // Inputs must already be masked to the commands that are legal in the
    // current state, so an illegal command can never shadow a legal one.
    function automatic cmd_e resolve_cmd(input logic stop,
                                         input logic pause,
                                         input logic go);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (stop) begin
            cmd = CMD_STOP;
        end else if (pause) begin
            cmd = CMD_PAUSE;
        end else if (go) begin
            cmd = CMD_GO;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/seq_term_gen.sv
// -----------------------------------------------------------------------------
// seq_term_gen
// Arithmetic-progression term register. Holds the current term, advances it
// by step (wrapping back to start once the next term would exceed limit) and
// reports whether the current / next term is the last one of a loop.
// The sum is formed in WIDTH+1 bits so an overflowing term is seen as
// "beyond limit" instead of silently wrapping to a small value.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   load_i         load start_i as the current term (takes precedence)
//   advance_i      move to the next term (or back to start_i on wrap)
//   start_i        first term of a loop
//   step_i         increment
//   limit_i        largest allowed term
//   value_o        current term (registered)
//   wrap_o         current term + step exceeds limit
//   wrap_next_o    the term being loaded this cycle + step exceeds limit
// -----------------------------------------------------------------------------
module seq_term_gen #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] start_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] value_o,
    output logic             wrap_o,
    output logic             wrap_next_o
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH:0]   sum_cur, sum_next;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_cur = {1'b0, value_q} + {1'b0, step_i};
        value_d = value_q;
        if (load_i) begin
            value_d = start_i;
        end else if (advance_i) begin
            value_d = (sum_cur > {1'b0, limit_i}) ? start_i : sum_cur[WIDTH-1:0];
        end
        sum_next = {1'b0, value_d} + {1'b0, step_i};
    end

    assign wrap_o      = (sum_cur  > {1'b0, limit_i});
    assign wrap_next_o = (sum_next > {1'b0, limit_i});

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/seq_run_controller.sv
// -----------------------------------------------------------------------------
// seq_run_controller
// Configurable arithmetic-progression sequencer with a valid/ready output
// stream. Emits start, start+step, ... up to limit, then wraps back to start;
// runs cfg_loops loops (0 = forever) under start/pause/resume/stop control.
// All outputs are registered.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_start/pause/resume/stop    single-cycle command pulses
//   cfg_start/step/limit/loops     configuration, latched on an honoured start
//   out_value/out_valid/out_ready  term stream (consumer paces via out_ready)
//   out_last                       current term is the final term of the run
//   loop_cnt                       completed loops since start (saturating)
//   busy                           RUN or PAUSE
//   done                           run finished
//   err_cfg                        one-cycle pulse on a rejected start
// -----------------------------------------------------------------------------
module seq_run_controller
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned LOOP_W = DEF_LOOP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_resume,
    input  logic              cmd_stop,
    input  logic [WIDTH-1:0]  cfg_start,
    input  logic [WIDTH-1:0]  cfg_step,
    input  logic [WIDTH-1:0]  cfg_limit,
    input  logic [LOOP_W-1:0] cfg_loops,
    output logic [WIDTH-1:0]  out_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [LOOP_W-1:0] loop_cnt,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  start_q, start_d;
    logic [WIDTH-1:0]  step_q, step_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [LOOP_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              load, advance;
    logic              wrap, wrap_next;
    logic [WIDTH-1:0]  value;

    logic              xfer;
    logic              pause_v, go_v;
    logic              cfg_ok;
    logic              final_loop;
    logic [LOOP_W-1:0] cnt_inc;
    cmd_e              cmd;

    assign xfer = valid_q & out_ready;

    // Mask commands to those legal in the current state before resolving
    // priority, so e.g. a stray pause in IDLE does not block a start.
    assign pause_v = cmd_pause & ((state_q == RUN) | (state_q == PAUSE));
    assign go_v    = (cmd_start  & ((state_q == IDLE) | (state_q == DONE)))
                   | (cmd_resume & (state_q == PAUSE));
    assign cmd     = resolve_cmd(cmd_stop, pause_v, go_v);

    assign cfg_ok     = (cfg_step != '0) && (cfg_start <= cfg_limit);
    // With loops != 0 the count never exceeds loops-1 here, so the +1 cannot wrap.
    assign final_loop = (loops_q != '0) && ((cnt_q + LOOP_W'(1)) == loops_q);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + LOOP_W'(1);

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        step_d  = step_q;
        limit_d = limit_q;
        loops_d = loops_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (cmd == CMD_STOP) begin
                    state_d = IDLE;
                end else if (cmd == CMD_GO) begin
                    start_d = cfg_start;
                    step_d  = cfg_step;
                    limit_d = cfg_limit;
                    loops_d = cfg_loops;
                    if (!cfg_ok) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cmd == CMD_STOP) begin
                    // A transfer in this cycle is consumed but does not advance.
                    state_d = IDLE;
                end else begin
                    if (xfer) begin
                        if (wrap && final_loop) begin
                            cnt_d   = cnt_q + LOOP_W'(1);
                            state_d = DONE;
                        end else begin
                            advance = 1'b1;
                            if (wrap) begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                    if ((cmd == CMD_PAUSE) && (state_d == RUN)) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (cmd == CMD_STOP) begin
                    state_d = IDLE;
                end else if (cmd == CMD_GO) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == PAUSE);
        done_d  = (state_d == DONE);
        // Registered alongside the term it describes.
        last_d  = valid_d && wrap_next && (loops_d != '0)
                  && (cnt_d == (loops_d - LOOP_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= '0;
            step_q  <= '0;
            limit_q <= '0;
            loops_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            loops_q <= loops_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Fed with next-cycle config so a load uses the new step/limit at once;
    // outside a start cycle these equal the latched values.
    seq_term_gen #(
        .WIDTH (WIDTH)
    ) u_term_gen (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .advance_i   (advance),
        .start_i     (start_d),
        .step_i      (step_d),
        .limit_i     (limit_d),
        .value_o     (value),
        .wrap_o      (wrap),
        .wrap_next_o (wrap_next)
    );

    assign out_value = value;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign loop_cnt  = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cfg   = err_q;

endmodule

// File: tb/tb_seq_run_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_run_controller
// Self-checking bench for seq_run_controller: directed scenarios followed by
// randomized commands/config/ready, all compared every cycle against a
// behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_seq_run_controller;

    localparam int WIDTH  = 4;
    localparam int LOOP_W = 4;
    localparam int MAXC   = (1 << LOOP_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_start, cmd_pause, cmd_resume, cmd_stop;
    logic [WIDTH-1:0]  cfg_start, cfg_step, cfg_limit;
    logic [LOOP_W-1:0] cfg_loops;
    logic [WIDTH-1:0]  out_value;
    logic              out_valid, out_ready, out_last;
    logic [LOOP_W-1:0] loop_cnt;
    logic              busy, done, err_cfg;

    always #5 clk = ~clk;

    seq_run_controller #(
        .WIDTH  (WIDTH),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_pause  (cmd_pause),
        .cmd_resume (cmd_resume),
        .cmd_stop   (cmd_stop),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_limit  (cfg_limit),
        .cfg_loops  (cfg_loops),
        .out_value  (out_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .loop_cnt   (loop_cnt),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_start, m_step, m_limit, m_loops;
    int m_val, m_cnt;
    bit m_run, m_pause, m_done, m_err;

    // Applies the rules for one clock edge, using the inputs sampled at it.
    task automatic model_step();
        bit xfer;
        int nc;
        xfer  = m_run && (out_ready === 1'b1);
        m_err = 1'b0;
        if (reset) begin
            m_run = 0; m_pause = 0; m_done = 0; m_val = 0; m_cnt = 0;
            return;
        end
        if (cmd_stop) begin
            m_run = 0; m_pause = 0; m_done = 0;
        end else if (m_run) begin
            if (xfer) begin
                if (m_val + m_step <= m_limit) begin
                    m_val = m_val + m_step;
                end else begin
                    nc = m_cnt + 1;
                    if (m_loops != 0 && nc == m_loops) begin
                        m_cnt = nc; m_run = 0; m_done = 1;
                    end else begin
                        m_cnt = (nc > MAXC) ? MAXC : nc;
                        m_val = m_start;
                    end
                end
            end
            if (cmd_pause && m_run) begin
                m_run = 0; m_pause = 1;
            end
        end else if (m_pause) begin
            if (!cmd_pause && cmd_resume) begin
                m_pause = 0; m_run = 1;
            end
        end else if (cmd_start) begin
            m_start = int'(cfg_start);
            m_step  = int'(cfg_step);
            m_limit = int'(cfg_limit);
            m_loops = int'(cfg_loops);
            if (m_step == 0 || m_start > m_limit) begin
                m_err = 1;
            end else begin
                m_done = 0; m_run = 1; m_val = m_start; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_last;
        exp_last = m_run && (m_loops != 0) && (m_cnt == m_loops - 1)
                   && (m_val + m_step > m_limit);
        check("out_value", 32'(out_value), 32'(m_val));
        check("out_valid", 32'(out_valid), 32'(m_run));
        check("out_last",  32'(out_last),  32'(exp_last));
        check("loop_cnt",  32'(loop_cnt),  32'(m_cnt));
        check("busy",      32'(busy),      32'(m_run | m_pause));
        check("done",      32'(done),      32'(m_done));
        check("err_cfg",   32'(err_cfg),   32'(m_err));
    endtask

    // One clock: inputs are already driven; sample #1 after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        cmd_start  = 1'b0;
        cmd_pause  = 1'b0;
        cmd_resume = 1'b0;
        cmd_stop   = 1'b0;
    endtask

    task automatic set_cfg(input int s, input int st, input int l, input int lp);
        cfg_start = WIDTH'(s);
        cfg_step  = WIDTH'(st);
        cfg_limit = WIDTH'(l);
        cfg_loops = LOOP_W'(lp);
    endtask

    int got_q[$];
    int exp_q[$];
    int last_at;

    initial begin
        reset = 1'b1;
        cmd_start = 0; cmd_pause = 0; cmd_resume = 0; cmd_stop = 0;
        out_ready = 1'b0;
        set_cfg(0, 0, 0, 0);
        m_start = 0; m_step = 0; m_limit = 0; m_loops = 0;
        m_val = 0; m_cnt = 0; m_run = 0; m_pause = 0; m_done = 0; m_err = 0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // ---- 1: 2/3/14, one loop, always ready ----
        set_cfg(2, 3, 14, 1);
        out_ready = 1'b1;
        cmd_start = 1'b1;
        cycle();
        set_cfg(0, 1, 1, 0);  // changes after the start must have no effect
        got_q.delete();
        last_at = -1;
        for (int i = 0; i < 12 && !done; i++) begin
            if (out_valid && out_ready) begin
                if (out_last) last_at = got_q.size();
                got_q.push_back(int'(out_value));
            end
            cycle();
        end
        exp_q = '{2, 5, 8, 11, 14};
        check("t1_len", got_q.size(), exp_q.size());
        foreach (got_q[i]) if (i < exp_q.size()) check("t1_term", got_q[i], exp_q[i]);
        check("t1_last_idx", last_at, 4);
        check("t1_done", 32'(done), 1);
        check("t1_loop_cnt", 32'(loop_cnt), 1);

        // ---- 2: 0/5/12, two loops, ready toggling ----
        set_cfg(0, 5, 12, 2);
        cmd_start = 1'b1;
        cycle();
        got_q.delete();
        for (int i = 0; i < 40 && !done; i++) begin
            out_ready = (i % 2 == 0);
            if (out_valid && out_ready) got_q.push_back(int'(out_value));
            cycle();
        end
        exp_q = '{0, 5, 10, 0, 5, 10};
        check("t2_len", got_q.size(), exp_q.size());
        foreach (got_q[i]) if (i < exp_q.size()) check("t2_term", got_q[i], exp_q[i]);
        check("t2_done", 32'(done), 1);
        check("t2_loop_cnt", 32'(loop_cnt), 2);

        // ---- 3: rejected starts ----
        cmd_stop = 1'b1;
        cycle();
        set_cfg(3, 0, 10, 1);
        cmd_start = 1'b1;
        cycle();
        check("t3_err_step0", 32'(err_cfg), 1);
        check("t3_valid_step0", 32'(out_valid), 0);
        cycle();
        check("t3_err_pulse", 32'(err_cfg), 0);
        set_cfg(9, 1, 4, 1);
        cmd_start = 1'b1;
        cycle();
        check("t3_err_range", 32'(err_cfg), 1);
        check("t3_busy_range", 32'(busy), 0);
        cycle();

        // ---- 4: pause with a transfer at 5 ----
        set_cfg(2, 3, 14, 0);
        out_ready = 1'b0;
        cmd_start = 1'b1;
        cycle();
        out_ready = 1'b1;
        cycle();
        check("t4_pre_pause", 32'(out_value), 5);
        cmd_pause = 1'b1;
        cycle();
        check("t4_adv_value", 32'(out_value), 8);
        check("t4_paused_valid", 32'(out_valid), 0);
        for (int i = 0; i < 3; i++) cycle();
        check("t4_frozen", 32'(out_value), 8);
        out_ready = 1'b0;
        cmd_resume = 1'b1;
        cycle();
        check("t4_resume_valid", 32'(out_valid), 1);
        check("t4_resume_value", 32'(out_value), 8);

        // ---- 5: stop and pause together ----
        out_ready = 1'b1;
        cmd_stop  = 1'b1;
        cmd_pause = 1'b1;
        cycle();
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(out_valid), 0);
        set_cfg(7, 2, 15, 1);
        cmd_start = 1'b1;
        cycle();
        check("t5_restart_value", 32'(out_value), 7);
        check("t5_restart_valid", 32'(out_valid), 1);

        // ---- 6: single-term overflow, saturating loop count, reset mid-run ----
        cmd_stop = 1'b1;
        cycle();
        set_cfg(13, 3, 15, 0);
        out_ready = 1'b1;
        cmd_start = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) cycle();
        check("t6_value", 32'(out_value), 13);
        check("t6_loop_sat", 32'(loop_cnt), 15);
        check("t6_busy", 32'(busy), 1);
        reset = 1'b1;
        cycle();
        check("t6_rst_value", 32'(out_value), 0);
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_cnt", 32'(loop_cnt), 0);
        check("t6_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        cycle();

        // ---- random ----
        for (int i = 0; i < 3000; i++) begin
            set_cfg($urandom_range(0, 15), $urandom_range(0, 6),
                    $urandom_range(0, 15), $urandom_range(0, 3));
            out_ready  = ($urandom_range(0, 3) != 0);
            cmd_start  = ($urandom_range(0, 7) == 0);
            cmd_pause  = ($urandom_range(0, 15) == 0);
            cmd_resume = ($urandom_range(0, 5) == 0);
            cmd_stop   = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_run_controller.md
Name: seq_run_controller

Overview:
- Programmable controller that sequences an arithmetic-progression counter: emits start, start+step, … up to limit, then wraps.
- Runs a configured number of loops, with start/pause/resume/stop commands.
- Output is a valid/ready stream, so a downstream consumer paces the sequence.
- Sits between the control register bank (cmd_*/cfg_*) and any consumer of sequence terms. It generalises the fixed 0-2-5-8-11-14 style counters into one configurable, flow-controlled block.

Parameters:
- WIDTH, 4, bit width of cfg_start/cfg_step/cfg_limit/out_value.
- LOOP_W, 4, bit width of cfg_loops and loop_cnt.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  single-cycle pulse; latch cfg_* and begin. Honoured only in IDLE or DONE.
- cmd_pause  in  1  single-cycle pulse; RUN -> PAUSE.
- cmd_resume  in  1  single-cycle pulse; PAUSE -> RUN.
- cmd_stop  in  1  single-cycle pulse; abort to IDLE from any state.
- cfg_start  in  WIDTH  first term.
- cfg_step  in  WIDTH  increment; must be non-zero.
- cfg_limit  in  WIDTH  largest allowed term.
- cfg_loops  in  LOOP_W  loops to run; 0 = run forever.
- out_value  out  WIDTH  current term.
- out_valid  out  1  out_value is valid.
- out_ready  in  1  consumer accepts out_value.
- out_last  out  1  current term is the final term of the final loop.
- loop_cnt  out  LOOP_W  completed loops since start.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.
- err_cfg  out  1  one-cycle pulse on a rejected start.

Behaviour:
- **Reset** (synchronous, active-high):
  - State is IDLE.
  - out_value=0, out_valid=0, out_last=0, loop_cnt=0, busy=0, done=0, err_cfg=0.
  - Reset asserted mid-run discards all progress.
- **States:** IDLE, RUN, PAUSE, DONE. All outputs are registered.
- **Command priority** within one cycle: cmd_stop > cmd_pause > cmd_resume/cmd_start. Commands not valid in the current state are ignored.
- **IDLE**, on cmd_start:
  - Latch cfg_* into internal registers. cfg_* may change afterwards without effect.
  - If cfg_step==0 or cfg_start>cfg_limit: err_cfg=1 for one cycle and stay in IDLE.
  - Otherwise, next cycle: RUN, out_value=cfg_start, out_valid=1, loop_cnt=0. Latency is 1 cycle from cmd_start to the first valid term.
- **RUN**:
  - out_valid=1.
  - out_value is held stable while out_valid && !out_ready.
  - A transfer is a cycle with out_valid && out_ready. Per transfer:
    - next = out_value + step, computed in WIDTH+1 bits so there is no silent wrap.
    - If next <= limit: out_value <= next.
    - Else (end of loop): loop_cnt <= loop_cnt+1.
      - If loops!=0 and loop_cnt+1==loops: go to DONE, out_valid <= 0, out_value held.
      - Otherwise out_value <= start.
- **loop_cnt overflow:** with loops==0, loop_cnt saturates at its maximum value and does not wrap.
- **out_last** = (value+step > limit) && loops!=0 && loop_cnt==loops-1. It is registered, so it is valid alongside out_value.
- **cmd_pause in RUN:**
  - A transfer in the same cycle still completes and advances.
  - Next cycle: PAUSE, out_valid=0, out_value and loop_cnt frozen.
  - The consumer must tolerate valid dropping without a transfer.
- **cmd_resume in PAUSE:** next cycle RUN with out_valid=1 and the same out_value.
- **cmd_stop from RUN, PAUSE or DONE:**
  - Next cycle: IDLE, out_valid=0, busy=0, done=0.
  - A transfer in the stop cycle counts as consumed by the consumer but does not advance out_value.
  - out_value and loop_cnt hold their last values until the next start.
- **DONE:**
  - done=1 and held; out_valid=0.
  - cmd_start restarts directly using the same validation and 1-cycle latency as IDLE. done drops on the start cycle +1.
- **Single-term sequence** (start+step > limit): every transfer is an end-of-loop.

Decomposition:
- Package seq_ctrl_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - default WIDTH and LOOP_W;
  - the command-priority ordering as named constants.
- Sub-module seq_term_gen is the datapath: value register, WIDTH+1 adder and limit compare, load-start and advance controls, and outputs value and wrap.
- The FSM, loop counter and handshake logic stay in seq_run_controller.

Test Plan:
1. cfg 2/3/14, loops=1, out_ready=1 -> terms 2,5,8,11,14 on consecutive cycles; out_last only with 14; done=1 the cycle after; loop_cnt=1.
2. cfg 0/5/12, loops=2, out_ready toggled 1,0,1,0… -> 0,5,10,0,5,10 with each value held through ready=0 cycles; done after 6 transfers.
3. cmd_start with cfg_step=0, then with cfg_start=9, limit=4 -> err_cfg one-cycle pulse each time; state stays IDLE; out_valid=0.
4. Pause with a transfer at value 5 (2/3/14 run) -> advances to 8, then out_valid=0 for 3 paused cycles; resume -> out_valid=1, value=8.
5. cmd_stop and cmd_pause in the same cycle in RUN -> IDLE next cycle, busy=0; a new cmd_start yields cfg_start after 1 cycle.
6. WIDTH=4, cfg 13/3/15, loops=0 -> 13,13,13… (13+3=16 detected, no wrap to 0); loop_cnt saturates at 15; reset mid-run -> all outputs 0 next cycle.
